// File: rtl/mc_datapath.sv
// Multicycle ARM-style datapath: PC, instruction/data registers, 15-entry register file, ALU with flags.
// Defining MC_DATAPATH_MUL_EN adds an iterative shift-add multiplier that writes its product into ALUOut.
module mc_datapath #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] Adr,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData,
    output logic [31:0]      Instr,
    output logic [3:0]       ALUFlags,
    input  logic             PCWrite,
    input  logic             RegWrite,
    input  logic             IRWrite,
    input  logic             AdrSrc,
    input  logic [1:0]       RegSrc,
    input  logic [1:0]       ALUSrcA,
    input  logic [1:0]       ALUSrcB,
    input  logic [1:0]       ResultSrc,
    input  logic [1:0]       ImmSrc,
    input  logic [2:0]       ALUControl,
    input  logic             MulStart,
    output logic             MulBusy,
    output logic             MulDone
);
    logic [WIDTH-1:0] pc_reg, data_reg, a_reg, write_data_reg, alu_out_reg;
    logic [31:0]      instr_reg;
    logic [WIDTH-1:0] result, alu_result, src_a, src_b, src_b_eff, ext_imm, rd1, rd2;
    logic [WIDTH:0]   sum;
    logic [3:0]       ra1, ra2;
    logic             sub_op, logic_op;
    logic             mul_load;
    logic [WIDTH-1:0] mul_product;
    logic             unused_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg         <= RESET_PC;
            instr_reg      <= '0;
            data_reg       <= '0;
            a_reg          <= '0;
            write_data_reg <= '0;
            alu_out_reg    <= '0;
        end else begin
            if (PCWrite) pc_reg <= result;
            if (IRWrite) instr_reg <= ReadData[31:0];
            data_reg       <= ReadData;
            a_reg          <= rd1;
            write_data_reg <= rd2;
            alu_out_reg    <= mul_load ? mul_product : alu_result;
        end
    end

    // Entry 15 is not storage: reading R15 yields the current Result.
    logic [WIDTH-1:0] rf_q [16];
    genvar gi;
    for (gi = 0; gi < 15; gi++) begin : g_rf
        logic [WIDTH-1:0] entry_reg;
        always_ff @(posedge clk or negedge reset) begin
            if (!reset)
                entry_reg <= '0;
            else if (RegWrite && (instr_reg[15:12] == 4'(gi)))
                entry_reg <= result;
        end
        assign rf_q[gi] = entry_reg;
    end
    assign rf_q[15] = result;

    assign ra1 = RegSrc[0] ? 4'hF : instr_reg[19:16];
    assign ra2 = RegSrc[1] ? instr_reg[15:12] : instr_reg[3:0];
    assign rd1 = rf_q[ra1];
    assign rd2 = rf_q[ra2];

    always_comb begin
        case (ImmSrc)
            2'b00:   ext_imm = {{(WIDTH-8){1'b0}}, instr_reg[7:0]};
            2'b01:   ext_imm = {{(WIDTH-12){1'b0}}, instr_reg[11:0]};
            2'b10:   ext_imm = {{(WIDTH-26){instr_reg[23]}}, instr_reg[23:0], 2'b00};
            default: ext_imm = '0;
        endcase
    end

    always_comb begin
        case (ALUSrcA)
            2'b00:   src_a = a_reg;
            2'b01:   src_a = pc_reg;
            2'b10:   src_a = alu_out_reg;
            default: src_a = '0;
        endcase
        case (ALUSrcB)
            2'b00:   src_b = write_data_reg;
            2'b01:   src_b = ext_imm;
            2'b10:   src_b = WIDTH'(4);
            default: src_b = '0;
        endcase
    end

    // SUB is a + ~b + 1, so the adder carry is the not-borrow flag directly.
    assign sub_op    = (ALUControl == 3'b001);
    assign src_b_eff = sub_op ? ~src_b : src_b;
    assign sum       = {1'b0, src_a} + {1'b0, src_b_eff} + {{WIDTH{1'b0}}, sub_op};

    always_comb begin
        logic_op = 1'b1;
        case (ALUControl)
            3'b010:  alu_result = src_a & src_b;
            3'b011:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a ^ src_b;
            default: begin
                alu_result = sum[WIDTH-1:0];
                logic_op   = 1'b0;
            end
        endcase
    end

    assign ALUFlags[3] = alu_result[WIDTH-1];
    assign ALUFlags[2] = (alu_result == '0);
    assign ALUFlags[1] = !logic_op && sum[WIDTH];
    assign ALUFlags[0] = !logic_op && (src_a[WIDTH-1] == src_b_eff[WIDTH-1])
                                   && (sum[WIDTH-1] != src_a[WIDTH-1]);

    always_comb begin
        case (ResultSrc)
            2'b00:   result = alu_out_reg;
            2'b01:   result = data_reg;
            default: result = alu_result;
        endcase
    end

    assign Adr       = AdrSrc ? result : pc_reg;
    assign WriteData = write_data_reg;
    assign Instr     = instr_reg;

`ifdef MC_DATAPATH_MUL_EN
    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_t;
    localparam int                CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_t       mul_state_reg;
    logic [WIDTH-1:0] mcand_reg, mplier_reg, prod_reg;
    logic [CNT_W-1:0] mul_cnt_reg;
    logic             mul_busy_reg, mul_done_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_state_reg <= MUL_IDLE;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            prod_reg      <= '0;
            mul_cnt_reg   <= '0;
            mul_busy_reg  <= 1'b0;
            mul_done_reg  <= 1'b0;
        end else begin
            case (mul_state_reg)
                MUL_IDLE: if (MulStart) begin
                    mcand_reg     <= a_reg;
                    mplier_reg    <= write_data_reg;
                    prod_reg      <= '0;
                    mul_cnt_reg   <= '0;
                    mul_busy_reg  <= 1'b1;
                    mul_state_reg <= MUL_RUN;
                end
                MUL_RUN: begin
                    // One multiplier bit per cycle; only the low WIDTH product bits are kept.
                    if (mplier_reg[0]) prod_reg <= prod_reg + mcand_reg;
                    mcand_reg   <= mcand_reg << 1;
                    mplier_reg  <= mplier_reg >> 1;
                    mul_cnt_reg <= mul_cnt_reg + 1'b1;
                    if (mul_cnt_reg == LAST_STEP) begin
                        mul_done_reg  <= 1'b1;
                        mul_state_reg <= MUL_DONE;
                    end
                end
                default: begin
                    mul_busy_reg  <= 1'b0;
                    mul_done_reg  <= 1'b0;
                    mul_state_reg <= MUL_IDLE;
                end
            endcase
        end
    end

    assign mul_load    = mul_done_reg;
    assign mul_product = prod_reg;
    assign MulBusy     = mul_busy_reg;
    assign MulDone     = mul_done_reg;
    assign unused_ok   = ^instr_reg[31:24];
`else
    assign mul_load    = 1'b0;
    assign mul_product = '0;
    assign MulBusy     = 1'b0;
    assign MulDone     = 1'b0;
    assign unused_ok   = ^{instr_reg[31:24], MulStart};
`endif
endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: vector table, randomized ALU against an arithmetic model,
// register-file shadow, PC/immediate paths, reset behaviour and (when enabled) the multiplier.
module tb_mc_datapath;
    localparam logic [31:0] RESET_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Adr, WriteData, ReadData, Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0]  ALUControl;
    logic        MulStart, MulBusy, MulDone;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mc_datapath #(.WIDTH(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .ReadData(ReadData),
        .Instr(Instr), .ALUFlags(ALUFlags), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
        .MulStart(MulStart), .MulBusy(MulBusy), .MulDone(MulDone)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;
    } alu_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic defaults();
        PCWrite = 0; RegWrite = 0; IRWrite = 0; AdrSrc = 1;
        RegSrc = 2'b00; ALUSrcA = 2'b00; ALUSrcB = 2'b00; ResultSrc = 2'b10;
        ImmSrc = 2'b00; ALUControl = 3'b000; MulStart = 0;
    endtask

    task automatic load_instr(input logic [31:0] v);
        defaults();
        ReadData = v; IRWrite = 1; tick();
        IRWrite = 0;
    endtask

    // Result = A + 0 exposes register A on Adr.
    task automatic read_a(output logic [31:0] v);
        ALUSrcA = 2'b00; ALUSrcB = 2'b11; ALUControl = 3'b000; ResultSrc = 2'b10; AdrSrc = 1;
        #1 v = Adr;
    endtask

    task automatic write_reg(input int k, input logic [31:0] v);
        load_instr((32'(k) << 16) | (32'(k) << 12));
        ReadData = v; tick();
        ResultSrc = 2'b01; RegWrite = 1; tick();
        RegWrite = 0; ResultSrc = 2'b10; tick();
    endtask

    task automatic read_reg(input int k, output logic [31:0] v);
        load_instr(32'(k) << 16);
        tick();
        read_a(v);
    endtask

    // Leaves A=a and WriteData=b in the current cycle (b goes through R2, a through R15=Result=Data).
    task automatic set_ab(input logic [31:0] a, input logic [31:0] b);
        load_instr(32'h0000_2002);
        ReadData = b; tick();
        ResultSrc = 2'b01; RegWrite = 1; ReadData = a; tick();
        RegWrite = 0; RegSrc = 2'b01; tick();
    endtask

    function automatic void alu_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic [3:0] f);
        longint sa, sb, ua, ub, full;
        logic c, v;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
        c = 1'b0; v = 1'b0; full = 0;
        case (op)
            3'd1: begin
                r = a - b; c = (ua >= ub);
                full = sa - sb; v = (full != longint'($signed(r)));
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: begin
                r = a + b; c = ((ua + ub) > 64'h0000_0000_FFFF_FFFF);
                full = sa + sb; v = (full != longint'($signed(r)));
            end
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    function automatic logic [31:0] imm_model(input logic [31:0] instr, input logic [1:0] sel);
        logic signed [23:0] s;
        s = instr[23:0];
        case (sel)
            2'd0:    return instr & 32'hFF;
            2'd1:    return instr & 32'hFFF;
            2'd2:    return 32'(int'(s) * 4);
            default: return 32'd0;
        endcase
    endfunction

    task automatic apply_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] res, input logic [3:0] flags);
        set_ab(a, b);
        ALUSrcA = 2'b00; ALUSrcB = 2'b00; ALUControl = op; ResultSrc = 2'b10; AdrSrc = 1;
        #1;
        $display("alu op=%0d a=%08h b=%08h -> res=%08h flags=%04b", op, a, b, Adr, ALUFlags);
        chk("alu_result", Adr, res);
        chk("alu_flags", {28'd0, ALUFlags}, {28'd0, flags});
        chk("write_data", WriteData, b);
        tick();
        ResultSrc = 2'b00; #1;
        chk("alu_out", Adr, res);
    endtask

`ifdef MC_DATAPATH_MUL_EN
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] exp;
        int lat;
        exp = a * b;
        set_ab(a, b);
        MulStart = 1; tick();
        MulStart = 0; #1;
        chk("mul_busy_start", {31'd0, MulBusy}, 32'd1);
        for (lat = 1; lat <= 40; lat++) begin
            if (MulDone) break;
            MulStart = (poke && lat == 5);
            tick();
            MulStart = 0;
        end
        $display("mul %08h*%08h latency=%0d", a, b, lat);
        chk("mul_latency", 32'(lat), 32'd33);
        chk("mul_busy_done", {31'd0, MulBusy}, 32'd1);
        tick();
        ResultSrc = 2'b00; AdrSrc = 1; #1;
        chk("mul_product", Adr, exp);
        chk("mul_done_pulse", {31'd0, MulDone}, 32'd0);
        chk("mul_busy_clear", {31'd0, MulBusy}, 32'd0);
    endtask
`endif

    initial begin
        alu_vec_t    vecs [10];
        logic [31:0] shadow [15];
        logic [31:0] v, r, instrs [2];
        logic [3:0]  f;
        logic [2:0]  op;
        int          done_seen;

        vecs[0] = '{3'd1, 32'd5,         32'd5,         32'd0,         4'b0110};
        vecs[1] = '{3'd1, 32'd0,         32'd1,         32'hFFFF_FFFF, 4'b1000};
        vecs[2] = '{3'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b1001};
        vecs[3] = '{3'd0, 32'hFFFF_FFFF, 32'd1,         32'd0,         4'b0110};
        vecs[4] = '{3'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000};
        vecs[5] = '{3'd3, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 4'b0000};
        vecs[6] = '{3'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 32'd0,         4'b0100};
        vecs[7] = '{3'd7, 32'd2,         32'd3,         32'd5,         4'b0000};
        vecs[8] = '{3'd1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0011};
        vecs[9] = '{3'd5, 32'h8000_0000, 32'h8000_0000, 32'd0,         4'b0111};
        instrs[0] = 32'h0080_0F85;
        instrs[1] = 32'h0012_3456;

        // Reset state
        defaults();
        ReadData = 32'd0; reset = 0;
        tick(); tick();
        AdrSrc = 0; #1;
        chk("reset_pc", Adr, RESET_PC);
        chk("reset_instr", Instr, 32'd0);
        chk("reset_wdata", WriteData, 32'd0);
        chk("reset_busy", {31'd0, MulBusy}, 32'd0);
        chk("reset_done", {31'd0, MulDone}, 32'd0);
        AdrSrc = 1; ResultSrc = 2'b00; #1;
        chk("reset_aluout", Adr, 32'd0);
        tick(); reset = 1;
        defaults(); AdrSrc = 0; tick(); #1;
        chk("pc_hold", Adr, RESET_PC);

        // Register file: write each entry, see it in A one cycle later, then R15 write is ignored
        for (int k = 0; k < 15; k++) begin
            v = (k == 3) ? 32'hDEAD_BEEF : $urandom;
            shadow[k] = v;
            write_reg(k, v);
            read_a(r);
            $display("rf write r%0d=%08h read=%08h", k, v, r);
            chk("rf_write_read", r, v);
        end
        write_reg(15, 32'h1234_5678);
        for (int k = 0; k < 15; k++) begin
            read_reg(k, r);
            chk("rf_after_r15", r, shadow[k]);
        end

        // Immediate extension
        for (int i = 0; i < 2; i++) begin
            load_instr(instrs[i]);
            for (int s = 0; s < 4; s++) begin
                ALUSrcA = 2'b11; ALUSrcB = 2'b01; ImmSrc = 2'(s); ResultSrc = 2'b10; AdrSrc = 1;
                #1 chk("ext_imm", Adr, imm_model(instrs[i], 2'(s)));
                tick();
            end
        end

        // PC + 4
        defaults(); ReadData = 32'h100; tick();
        ResultSrc = 2'b01; PCWrite = 1; tick();
        defaults(); ALUSrcA = 2'b01; ALUSrcB = 2'b10; PCWrite = 1; AdrSrc = 0; #1;
        chk("pc_before", Adr, 32'h100);
        AdrSrc = 1; #1 chk("pc_plus4_result", Adr, 32'h104);
        tick();
        PCWrite = 0; AdrSrc = 0; #1 chk("pc_after", Adr, 32'h104);
        ALUSrcA = 2'b10; AdrSrc = 1; #1 chk("aluout_plus4", Adr, 32'h108);
        ALUSrcA = 2'b11; ResultSrc = 2'b11; #1 chk("zero_plus4", Adr, 32'd4);

        // ALU vector table
        for (int i = 0; i < 10; i++)
            apply_alu(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flags);

        // Randomized ALU
        for (int i = 0; i < 20; i++) begin
            op = 3'($urandom_range(0, 7));
            v  = $urandom;
            r  = (i % 4 == 0) ? v : $urandom;
            alu_model(op, v, r, shadow[0], f);
            apply_alu(op, v, r, shadow[0], f);
        end

`ifdef MC_DATAPATH_MUL_EN
        run_mul(32'd7, 32'd6, 1'b1);
        for (int i = 0; i < 3; i++) run_mul($urandom, $urandom, 1'b0);
        set_ab(32'd3, 32'd5);
        MulStart = 1; tick();
        MulStart = 0; tick(); tick(); #1;
        chk("mid_busy", {31'd0, MulBusy}, 32'd1);
`else
        defaults(); MulStart = 1; tick();
        MulStart = 0; #1;
        chk("nomul_busy", {31'd0, MulBusy}, 32'd0);
        chk("nomul_done", {31'd0, MulDone}, 32'd0);
`endif

        // Reset mid-run
        AdrSrc = 0; #1 reset = 0; #1;
        chk("midreset_pc", Adr, RESET_PC);
        chk("midreset_instr", Instr, 32'd0);
        chk("midreset_busy", {31'd0, MulBusy}, 32'd0);
        AdrSrc = 1; ResultSrc = 2'b00; #1;
        chk("midreset_aluout", Adr, 32'd0);
        tick(); reset = 1;
        defaults();
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (MulDone || MulBusy) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (legal range 32 and above).
REQ-002 SHALL have parameter RESET_PC, default 0, the PC value loaded at reset.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have these ports, one per line as name, direction, width, meaning:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- Adr  out  WIDTH  memory address
- WriteData  out  WIDTH  registered RD2, store data
- ReadData  in  WIDTH  memory read data
- Instr  out  32  instruction register
- ALUFlags  out  4  {N,Z,C,V} of current ALUResult
- PCWrite, RegWrite, IRWrite, AdrSrc  in  1 each  controller enables/selects
- RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc  in  2 each  controller selects
- ALUControl  in  3  ALU operation
- MulStart  in  1  start iterative multiply
- MulBusy  out  1  multiplier running
- MulDone  out  1  one-cycle pulse when product is in ALUOut

Function
REQ-005 SHALL hold PC in a WIDTH-bit register that loads Result when PCWrite=1.
REQ-006 SHALL drive Adr = AdrSrc ? Result : PC.
REQ-007 SHALL load Instr from ReadData[31:0] when IRWrite=1; otherwise hold.
REQ-008 SHALL register Data<=ReadData, A<=RD1 and WriteData<=RD2 every cycle.
REQ-009 SHALL select RA1 = RegSrc[0] ? 15 : Instr[19:16], and RA2 = RegSrc[1] ? Instr[15:12] : Instr[3:0].
REQ-010 SHALL contain a 15-entry register file (R0-R14):
- combinational read
- synchronous write of Result to Instr[15:12] when RegWrite=1
- a write to index 15 is ignored
- a read of index 15 returns Result
REQ-011 SHALL produce ExtImm by ImmSrc:
- 00: zero-extended Instr[7:0]
- 01: zero-extended Instr[11:0]
- 10: sign-extended {Instr[23:0],2'b00}
- 11: zero
REQ-012 SHALL select SrcA by ALUSrcA: 00 A, 01 PC, 10 ALUOut, 11 zero.
REQ-013 SHALL select SrcB by ALUSrcB: 00 WriteData, 01 ExtImm, 10 constant 4, 11 zero.
REQ-014 SHALL compute ALUResult by ALUControl:
- 000 ADD, 001 SUB (SrcA-SrcB), 010 AND, 011 ORR, 100 EOR
- all other codes behave as ADD
REQ-015 SHALL compute the flags as follows:
- N = ALUResult MSB; Z = ALUResult==0
- C = carry out for ADD, not-borrow for SUB, 0 for logic ops
- V = signed overflow for ADD/SUB, 0 otherwise
REQ-016 SHALL select Result by ResultSrc: 00 ALUOut, 01 Data, 10 and 11 ALUResult.
REQ-017 SHALL register ALUOut<=ALUResult every cycle, except in the cycle the multiplier completes.
REQ-018 SHALL run a multiplier FSM with states IDLE, RUN, DONE:
- IDLE->RUN on MulStart=1; captures A as multiplicand and WriteData as multiplier
- RUN iterates shift-add for exactly WIDTH cycles, then ->DONE
- DONE writes the low WIDTH bits of the product to ALUOut, then ->IDLE
REQ-019 SHALL assert MulBusy in RUN and DONE, and assert MulDone only in DONE; MulStart SHALL be ignored unless the FSM is IDLE.
REQ-020 SHALL make the MulStart-to-MulDone latency WIDTH+1 cycles; the product is readable via ResultSrc=00 in the cycle after MulDone.
REQ-021 SHALL keep all non-multiplier paths fully functional while MulBusy=1.

Reset
REQ-022 SHALL, while reset=0, asynchronously force the following state:
- PC=RESET_PC
- Instr, Data, A, WriteData and ALUOut = 0
- all register-file entries = 0
- multiplier FSM in IDLE, so MulBusy=0 and MulDone=0
REQ-023 SHALL abort any in-flight multiply on reset, with no ALUOut update.

Configuration
REQ-024 SHALL compile the multiplier only when macro MC_DATAPATH_MUL_EN is defined.
REQ-025 SHALL, without MC_DATAPATH_MUL_EN:
- ignore MulStart
- tie MulBusy=0 and MulDone=0
- load ALUOut from ALUResult every cycle

Verification
REQ-026 The bench SHALL cover: reset=0 mid-run -> PC=RESET_PC, Instr=0, MulBusy=0 immediately.
REQ-027 The bench SHALL cover: SrcA=PC=0x100, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 -> PC=0x104 next edge.
REQ-028 The bench SHALL cover: SUB with A=5, WriteData=5 -> ALUFlags=0110; SUB with A=0, WriteData=1 -> ALUResult=0xFFFFFFFF, ALUFlags=1000.
REQ-029 The bench SHALL cover: ADD 0x7FFFFFFF+1 -> ALUFlags=1001.
REQ-030 The bench SHALL cover: RegWrite=1, Instr[15:12]=3, Result=0xDEADBEEF, then RA1=3 -> A=0xDEADBEEF one cycle later; a write to index 15 leaves R0-R14 unchanged.
REQ-031 The bench SHALL cover: with MC_DATAPATH_MUL_EN defined, A=7, WriteData=6, MulStart pulse -> MulDone after 33 cycles, ALUOut=42; a second MulStart while busy is ignored.
